// File: rtl/arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } owner_e;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port
// that did not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot selection from the request vector and last winner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a zero-latency data memory.
// Owner retention with lock and hold limit, round-robin on ties,
// and saturating per-port conflict counters.
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic                    lock0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]   wdata0,
    input  logic [DATA_WIDTH/8-1:0] wstrb0,
    input  logic                    write0,
    input  logic                    req1,
    input  logic                    lock1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]   wdata1,
    input  logic [DATA_WIDTH/8-1:0] wstrb1,
    input  logic                    write1,
    output logic                    gnt0,
    output logic [DATA_WIDTH-1:0]   rdata0,
    output logic                    gnt1,
    output logic [DATA_WIDTH-1:0]   rdata1,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [15:0]             conflict0,
    output logic [15:0]             conflict1
);

    localparam int             SW       = DATA_WIDTH / 8;
    localparam int             HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]  HOLD_LIM = HW'(MAX_HOLD);

    owner_e          owner_q, owner_d;
    logic            last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [15:0]     conf0_q, conf0_d;
    logic [15:0]     conf1_q, conf1_d;

    logic [1:0]      rr_gnt_s;
    logic [1:0]      gnt_s;
    logic            keep0_s, keep1_s;

    rr_pick2 u_rr_pick2 (
        .req   ({req1, req0}),
        .last  (last_q),
        .grant (rr_gnt_s)
    );

    // Grant decision: reset forces idle, a qualifying owner keeps the
    // bus, otherwise the round-robin pick decides.
    always_comb begin
        keep0_s = (owner_q == P0) && req0 && (lock0 || !req1 || (hold_q < HOLD_LIM));
        keep1_s = (owner_q == P1) && req1 && (lock1 || !req0 || (hold_q < HOLD_LIM));
        gnt_s   = 2'b00;
        if (rst_n) begin
            gnt_s = 2'b00;
        end else if (keep0_s) begin
            gnt_s = 2'b01;
        end else if (keep1_s) begin
            gnt_s = 2'b10;
        end else begin
            gnt_s = rr_gnt_s;
        end
    end

    // Memory-side mux of the granted port; all zero when idle.
    always_comb begin
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        mem_wstrb = {SW{1'b0}};
        mem_write = 1'b0;
        mem_read  = 1'b0;
        case (gnt_s)
            2'b01: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_wstrb = wstrb0;
                mem_write = write0;
                mem_read  = !write0;
            end
            2'b10: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_wstrb = wstrb1;
                mem_write = write1;
                mem_read  = !write1;
            end
            default: begin
                mem_addr  = {ADDR_WIDTH{1'b0}};
                mem_wdata = {DATA_WIDTH{1'b0}};
                mem_wstrb = {SW{1'b0}};
                mem_write = 1'b0;
                mem_read  = 1'b0;
            end
        endcase
    end

    // Next owner, last winner, hold count and conflict counters.
    always_comb begin
        owner_d = NONE;
        last_d  = last_q;
        hold_d  = {HW{1'b0}};
        case (gnt_s)
            2'b01: begin
                owner_d = P0;
                last_d  = 1'b0;
            end
            2'b10: begin
                owner_d = P1;
                last_d  = 1'b1;
            end
            default: begin
                owner_d = NONE;
                last_d  = last_q;
            end
        endcase
        if (gnt_s != 2'b00) begin
            if (owner_d == owner_q) begin
                hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + HW'(1);
            end else begin
                hold_d = HW'(1);
            end
        end else begin
            hold_d = {HW{1'b0}};
        end
        conf0_d = (req0 && !gnt_s[0]) ? sat_inc16(conf0_q) : conf0_q;
        conf1_d = (req1 && !gnt_s[1]) ? sat_inc16(conf1_q) : conf1_q;
    end

    // State registers; reset aborts any ownership at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            owner_q <= NONE;
            last_q  <= 1'b1;
            hold_q  <= {HW{1'b0}};
            conf0_q <= 16'h0000;
            conf1_q <= 16'h0000;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            conf0_q <= conf0_d;
            conf1_q <= conf1_d;
        end
    end

    assign gnt0      = gnt_s[0];
    assign gnt1      = gnt_s[1];
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;
    assign conflict0 = conf0_q;
    assign conflict1 = conf1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small memory model.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, lock0, write0, req1, lock1, write1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic        gnt0, gnt1, mem_write, mem_read;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] conflict0, conflict1;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_arr [0:255];

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .wstrb0(wstrb0), .write0(write0),
        .req1(req1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1), .write1(write1),
        .gnt0(gnt0), .rdata0(rdata0), .gnt1(gnt1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .conflict0(conflict0), .conflict1(conflict1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency memory model: combinational read, byte-strobed write.
    assign mem_rdata = mem_arr[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem_arr[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic l, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req0 = r; lock0 = l; write0 = w; addr0 = a; wdata0 = d; wstrb0 = s;
    endtask

    task automatic set1(input logic r, input logic l, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req1 = r; lock1 = l; write1 = w; addr1 = a; wdata1 = d; wstrb1 = s;
    endtask

    task automatic idle();
        set0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        idle();
        rst_n = 1'b1;

        // Reset forces idle outputs even with both ports requesting.
        set0(1'b1, 1'b0, 1'b1, 32'h10, 32'h1, 4'hF);
        set1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        tick();
        #2;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_conf0", conflict0, 16'h0);
        check("rst_conf1", conflict1, 16'h0);
        tick();
        rst_n = 1'b0;

        // Tie after reset: P0 holds 4 cycles, P1 holds 4, then P0 again.
        set0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int i = 0; i < 12; i++) begin
            #2;
            check("tie_gnt0", gnt0, (i < 4 || i >= 8) ? 1'b1 : 1'b0);
            check("tie_gnt1", gnt1, (i >= 4 && i < 8) ? 1'b1 : 1'b0);
            if (i == 4) check("tie_conf1_at_first_gnt1", conflict1, 16'd4);
            if (i == 8) check("tie_conf0_after_p1_hold", conflict0, 16'd4);
            tick();
        end

        // No requests: everything idle.
        idle();
        #2;
        check("idle_gnt0", gnt0, 1'b0);
        check("idle_gnt1", gnt1, 1'b0);
        check("idle_mem_read", mem_read, 1'b0);
        check("idle_mem_addr", mem_addr, 32'h0);
        tick();

        // A lock from a non-owner does not preempt the owner.
        do_reset();
        set0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        check("npre_first_gnt0", gnt0, 1'b1);
        tick();
        set1(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        #2;
        check("npre_gnt0", gnt0, 1'b1);
        check("npre_gnt1", gnt1, 1'b0);
        tick();

        // Owner lock overrides the hold limit for 10 cycles.
        do_reset();
        set0(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        set1(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            #2;
            check("lock_gnt0", gnt0, 1'b1);
            check("lock_gnt1", gnt1, 1'b0);
            tick();
        end
        set0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        check("lock_release_gnt1", gnt1, 1'b1);
        check("lock_release_gnt0", gnt0, 1'b0);
        check("lock_conf1", conflict1, 16'd10);
        check("lock_conf0", conflict0, 16'd0);
        tick();

        // Data path: P1 writes, then P0 reads the same word back.
        do_reset();
        set1(1'b1, 1'b0, 1'b1, 32'h40, 32'hdeadbeef, 4'hF);
        #2;
        check("wr_gnt1", gnt1, 1'b1);
        check("wr_mem_write", mem_write, 1'b1);
        check("wr_mem_read", mem_read, 1'b0);
        check("wr_mem_addr", mem_addr, 32'h40);
        check("wr_mem_wdata", mem_wdata, 32'hdeadbeef);
        check("wr_mem_wstrb", mem_wstrb, 4'hF);
        tick();
        set1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set0(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
        #2;
        check("rd_gnt0", gnt0, 1'b1);
        check("rd_mem_write", mem_write, 1'b0);
        check("rd_mem_read", mem_read, 1'b1);
        check("rd_mem_addr", mem_addr, 32'h40);
        check("rd_rdata0", rdata0, 32'hdeadbeef);
        tick();

        // Asynchronous reset while P1 owns and writes.
        do_reset();
        set1(1'b1, 1'b0, 1'b1, 32'h80, 32'h12345678, 4'h3);
        tick();
        set0(1'b1, 1'b0, 1'b0, 32'h84, 32'h0, 4'h0);
        #2;
        check("mid_p1_keeps", gnt1, 1'b1);
        tick();
        #2;
        check("mid_conf0_before", conflict0, 16'd1);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_rst_gnt1", gnt1, 1'b0);
        check("mid_rst_mem_write", mem_write, 1'b0);
        check("mid_rst_conf0", conflict0, 16'd0);
        check("mid_rst_conf1", conflict1, 16'd0);
        tick();
        rst_n = 1'b0;
        set1(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0);
        #2;
        check("mid_post_gnt0", gnt0, 1'b1);
        check("mid_post_gnt1", gnt1, 1'b0);
        tick();

        // Saturation: P1 starved by a locked P0 for 70000 cycles.
        do_reset();
        set0(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0);
        repeat (65534) tick();
        #2;
        check("sat_conf1_fffe", conflict1, 16'hFFFE);
        repeat (70000 - 65534) tick();
        #2;
        check("sat_conf1_ffff", conflict1, 16'hFFFF);
        check("sat_gnt0", gnt0, 1'b1);
        check("sat_conf0", conflict0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
